// File: rtl/ram_access_unit_pkg.sv
// rtl/ram_access_unit_pkg.sv - RAM_access codes, bit-op opcodes and SP reset value shared by the RAM access unit
package ram_access_unit_pkg;

  localparam logic [3:0] NONE           = 4'd0;
  localparam logic [3:0] RD_RAM_REG     = 4'd1;
  localparam logic [3:0] WR_RAM_REG     = 4'd2;
  localparam logic [3:0] RD_RAM_REG_IND = 4'd3;
  localparam logic [3:0] WR_RAM_REG_IND = 4'd4;
  localparam logic [3:0] RD_RAM_DIRECT  = 4'd5;
  localparam logic [3:0] WR_RAM_DIRECT  = 4'd6;
  localparam logic [3:0] RD_RAM_IM      = 4'd7;
  localparam logic [3:0] WR_RAM_REG_IM  = 4'd8;
  localparam logic [3:0] WR_RAM_BIT     = 4'd9;
  localparam logic [3:0] RD_RAM_STACK   = 4'd10;
  localparam logic [3:0] WR_RAM_STACK   = 4'd11;

  localparam logic [7:0] SETB_B = 8'hD2;
  localparam logic [7:0] CLR_B  = 8'hC2;
  localparam logic [7:0] CPL_B  = 8'hB2;

  localparam logic [7:0] SP_RESET = 8'h07;

  // Codes whose first access cycle drives ram_we.
  function automatic logic is_write(input logic [3:0] code);
    return (code == WR_RAM_REG) || (code == WR_RAM_REG_IND) || (code == WR_RAM_DIRECT) ||
           (code == WR_RAM_REG_IM) || (code == WR_RAM_STACK);
  endfunction

endpackage

// File: rtl/ram_access_unit_bit_addr_decode.sv
// rtl/ram_access_unit_bit_addr_decode.sv - maps a bit address to its RAM/SFR byte address and bit mask
module bit_addr_decode (
  input  logic [7:0] operand,
  output logic [7:0] byte_addr,
  output logic [7:0] mask
);

  // Low 128 bits live in 0x20..0x2F; upper bits are in bit-addressable SFRs.
  assign byte_addr = operand[7] ? {operand[7:3], 3'b000} : (8'h20 + {4'b0000, operand[6:3]});
  assign mask      = 8'd1 << operand[2:0];

endmodule

// File: rtl/ram_access_unit.sv
// rtl/ram_access_unit.sv - internal RAM micro-op sequencer with stack pointer; RAM_ACCESS_STACK_OVF_EN enables stack_ovf
module ram_access_unit
  import ram_access_unit_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [3:0]  access,
  input  logic [7:0]  opcode,
  input  logic [7:0]  operand,
  input  logic [7:0]  acc,
  input  logic [1:0]  bank,
  input  logic [15:0] pc,
  input  logic [7:0]  ram_rdata,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_wdata,
  output logic        ram_we,
  output logic [7:0]  rdata,
  output logic [15:0] pc_pop,
  output logic [7:0]  sp,
  output logic        busy,
  output logic        done,
  output logic        stack_ovf
);

  typedef enum logic [3:0] {
    S_IDLE, S_PTR, S_PTR_W, S_ACC, S_RD_W, S_BIT_WR, S_STK2, S_STK2_W, S_DONE
  } state_t;

  state_t      state_q;
  logic [7:0]  ram_addr_q, ram_wdata_q, rdata_q, sp_q;
  logic [15:0] pc_pop_q;
  logic        ram_we_q, busy_q, done_q;

  logic [7:0] reg_addr, ri_addr, bit_byte, bit_mask, bit_new;
  logic [7:0] acc_addr, acc_wdata;
  logic       acc_we, is_push, is_pop, is_ind, sp_up, sp_dn;

  bit_addr_decode u_bit_dec (
    .operand   (operand),
    .byte_addr (bit_byte),
    .mask      (bit_mask)
  );

  assign reg_addr = {3'b000, bank, opcode[2:0]};
  assign ri_addr  = {3'b000, bank, 2'b00, opcode[0]};
  assign is_push  = (access == WR_RAM_STACK);
  assign is_pop   = (access == RD_RAM_STACK);
  assign is_ind   = (access == RD_RAM_REG_IND) || (access == WR_RAM_REG_IND);
  assign acc_we   = is_write(access);
  assign sp_up    = is_push && ((state_q == S_IDLE && start) || state_q == S_ACC);
  assign sp_dn    = is_pop && ((state_q == S_IDLE && start) || state_q == S_RD_W);

  // Address/data presented on entry to ACC; the indirect pointer is taken straight from ram_rdata in PTR_W.
  always_comb begin
    acc_addr  = 8'h00;
    acc_wdata = acc;
    case (access)
      RD_RAM_REG, WR_RAM_REG, WR_RAM_REG_IM: acc_addr = reg_addr;
      RD_RAM_REG_IND, WR_RAM_REG_IND:        acc_addr = ram_rdata;
      RD_RAM_DIRECT, WR_RAM_DIRECT:          acc_addr = operand;
      WR_RAM_BIT:                            acc_addr = bit_byte;
      RD_RAM_STACK:                          acc_addr = sp_q;
      WR_RAM_STACK:                          acc_addr = sp_q + 8'd1;
      default:                               acc_addr = 8'h00;
    endcase
    if (access == WR_RAM_REG_IM) acc_wdata = operand;
    else if (is_push)            acc_wdata = pc[7:0];
  end

  always_comb begin
    bit_new = ram_rdata;
    case (opcode)
      SETB_B:  bit_new = ram_rdata | bit_mask;
      CLR_B:   bit_new = ram_rdata & ~bit_mask;
      CPL_B:   bit_new = ram_rdata ^ bit_mask;
      default: bit_new = ram_rdata;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      ram_addr_q  <= 8'h00;
      ram_wdata_q <= 8'h00;
      ram_we_q    <= 1'b0;
      rdata_q     <= 8'h00;
      pc_pop_q    <= 16'h0000;
      sp_q        <= SP_RESET;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      done_q   <= 1'b0;
      if (sp_up)      sp_q <= sp_q + 8'd1;
      else if (sp_dn) sp_q <= sp_q - 8'd1;
      case (state_q)
        S_IDLE: if (start) begin
          busy_q <= 1'b1;
          if (access == RD_RAM_IM) begin
            rdata_q <= operand;
            state_q <= S_DONE;
          end else if (is_ind) begin
            ram_addr_q <= ri_addr;
            state_q    <= S_PTR;
          end else if (access == NONE || access > WR_RAM_STACK) begin
            state_q <= S_DONE;
          end else begin
            ram_addr_q  <= acc_addr;
            ram_wdata_q <= acc_wdata;
            ram_we_q    <= acc_we;
            state_q     <= S_ACC;
          end
        end
        S_PTR: state_q <= S_PTR_W;
        S_PTR_W: begin
          ram_addr_q  <= acc_addr;
          ram_wdata_q <= acc_wdata;
          ram_we_q    <= acc_we;
          state_q     <= S_ACC;
        end
        S_ACC: begin
          if (is_push) begin
            ram_addr_q  <= sp_q + 8'd1;
            ram_wdata_q <= pc[15:8];
            ram_we_q    <= 1'b1;
            state_q     <= S_STK2;
          end else if (acc_we) state_q <= S_DONE;
          else                 state_q <= S_RD_W;
        end
        S_RD_W: begin
          if (is_pop) begin
            pc_pop_q[15:8] <= ram_rdata;
            ram_addr_q     <= sp_q;
            state_q        <= S_STK2;
          end else if (access == WR_RAM_BIT) begin
            ram_wdata_q <= bit_new;
            ram_we_q    <= 1'b1;
            state_q     <= S_BIT_WR;
          end else begin
            rdata_q <= ram_rdata;
            state_q <= S_DONE;
          end
        end
        S_BIT_WR: state_q <= S_DONE;
        S_STK2:   state_q <= is_pop ? S_STK2_W : S_DONE;
        S_STK2_W: begin
          pc_pop_q[7:0] <= ram_rdata;
          state_q       <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

`ifdef RAM_ACCESS_STACK_OVF_EN
  logic ovf_q;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) ovf_q <= 1'b0;
    else if ((sp_up && sp_q == 8'hFF) || (sp_dn && sp_q == 8'h00)) ovf_q <= 1'b1;
  end
  assign stack_ovf = ovf_q;
`else
  assign stack_ovf = 1'b0;
`endif

  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;
  assign ram_we    = ram_we_q;
  assign rdata     = rdata_q;
  assign pc_pop    = pc_pop_q;
  assign sp        = sp_q;
  assign busy      = busy_q;
  assign done      = done_q;

endmodule

// File: tb/tb_ram_access_unit.sv
// tb/tb_ram_access_unit.sv - directed self-checking bench for ram_access_unit with a synchronous 256-byte RAM model
module tb_ram_access_unit;

  localparam bit OVF_EN =
`ifdef RAM_ACCESS_STACK_OVF_EN
    1'b1;
`else
    1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [3:0]  access = 4'd0;
  logic [7:0]  opcode = 8'h00, operand = 8'h00, acc = 8'h00;
  logic [1:0]  bank = 2'd0;
  logic [15:0] pc = 16'h0000;
  logic [7:0]  ram_rdata = 8'h00;
  logic [7:0]  ram_addr, ram_wdata, rdata, sp;
  logic [15:0] pc_pop;
  logic        ram_we, busy, done, stack_ovf;

  logic [7:0] mem [256];
  logic       pl_we = 1'b0;
  logic [7:0] pl_addr = 8'h00, pl_data = 8'h00;

  int errors = 0;
  int checks = 0;
  int lat, wes;

  ram_access_unit dut (
    .clock(clock), .reset(reset), .start(start), .access(access), .opcode(opcode),
    .operand(operand), .acc(acc), .bank(bank), .pc(pc), .ram_rdata(ram_rdata),
    .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_we(ram_we), .rdata(rdata),
    .pc_pop(pc_pop), .sp(sp), .busy(busy), .done(done), .stack_ovf(stack_ovf)
  );

  always #5 clock = ~clock;

  always @(posedge clock) begin
    if (pl_we)       mem[pl_addr] <= pl_data;
    else if (ram_we) mem[ram_addr] <= ram_wdata;
    ram_rdata <= mem[ram_addr];
  end

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic preload(input logic [7:0] a, input logic [7:0] d);
    pl_addr = a; pl_data = d; pl_we = 1'b1;
    @(posedge clock); #1 pl_we = 1'b0;
    @(negedge clock);
  endtask

  // Pulses start (held for 'hold' edges) and returns edges-to-done and the number of ram_we cycles seen.
  task automatic run_op(input logic [3:0] code, input int hold, output int l, output int w);
    access = code; start = 1'b1; l = 0; w = 0;
    while (l < 20) begin
      @(posedge clock); l++; #1;
      if (l >= hold) start = 1'b0;
      if (ram_we) w++;
      if (done) break;
    end
    start = 1'b0;
    @(negedge clock);
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check("rst_addr", ram_addr, 8'h00);
    check("rst_wdata", ram_wdata, 8'h00);
    check("rst_we", ram_we, 1'b0);
    check("rst_rdata", rdata, 8'h00);
    check("rst_pc_pop", pc_pop, 16'h0000);
    check("rst_sp", sp, 8'h07);
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_ovf", stack_ovf, 1'b0);
    reset = 1'b1;
    @(negedge clock);

    run_op(4'd0, 1, lat, wes);
    check("none_lat", lat, 2);

    bank = 2'd2; opcode = 8'hEB; acc = 8'h5A;
    run_op(4'd2, 1, lat, wes);
    check("wr_reg_lat", lat, 3);
    check("wr_reg_we", wes, 1);
    check("wr_reg_mem", mem[8'h13], 8'h5A);

    preload(8'h09, 8'h40); preload(8'h40, 8'h77);
    bank = 2'd1; opcode = 8'hE7;
    run_op(4'd3, 1, lat, wes);
    check("rd_ind_lat", lat, 6);
    check("rd_ind_data", rdata, 8'h77);

    operand = 8'h3C;
    run_op(4'd7, 1, lat, wes);
    check("rd_im_lat", lat, 2);
    check("rd_im_data", rdata, 8'h3C);

    bank = 2'd0; opcode = 8'h7D; operand = 8'hA5;
    run_op(4'd8, 1, lat, wes);
    check("wr_im_lat", lat, 3);
    check("wr_im_mem", mem[8'h05], 8'hA5);

    operand = 8'h13;
    run_op(4'd5, 1, lat, wes);
    check("rd_dir_lat", lat, 4);
    check("rd_dir_data", rdata, 8'h5A);

    operand = 8'h90; acc = 8'hC3;
    run_op(4'd6, 1, lat, wes);
    check("wr_dir_lat", lat, 3);
    check("wr_dir_mem", mem[8'h90], 8'hC3);

    preload(8'h18, 8'h66);
    bank = 2'd3; opcode = 8'hE8;
    run_op(4'd1, 1, lat, wes);
    check("rd_reg_lat", lat, 4);
    check("rd_reg_data", rdata, 8'h66);

    preload(8'h00, 8'h50);
    bank = 2'd0; opcode = 8'hF6; acc = 8'h99;
    run_op(4'd4, 1, lat, wes);
    check("wr_ind_lat", lat, 5);
    check("wr_ind_mem", mem[8'h50], 8'h99);

    preload(8'h2F, 8'h00);
    opcode = 8'hD2; operand = 8'h7B;
    run_op(4'd9, 1, lat, wes);
    check("setb_lat", lat, 5);
    check("setb_mem", mem[8'h2F], 8'h08);
    opcode = 8'hB2;
    run_op(4'd9, 1, lat, wes);
    check("cpl_mem", mem[8'h2F], 8'h00);
    preload(8'h80, 8'hFF);
    opcode = 8'hC2; operand = 8'h85;
    run_op(4'd9, 1, lat, wes);
    check("clr_sfr_mem", mem[8'h80], 8'hDF);

    run_op(4'hE, 1, lat, wes);
    check("undef_lat", lat, 2);
    check("undef_we", wes, 0);

    operand = 8'h44; acc = 8'h3B;
    run_op(4'd6, 2, lat, wes);
    check("busy_start_lat", lat, 3);
    repeat (2) @(negedge clock);
    check("busy_start_idle", busy, 1'b0);
    check("busy_start_mem", mem[8'h44], 8'h3B);

    pc = 16'h1234;
    run_op(4'd11, 1, lat, wes);
    check("push_lat", lat, 4);
    check("push_we", wes, 2);
    check("push_lo", mem[8'h08], 8'h34);
    check("push_hi", mem[8'h09], 8'h12);
    check("push_sp", sp, 8'h09);
    run_op(4'd10, 1, lat, wes);
    check("pop_lat", lat, 6);
    check("pop_pc", pc_pop, 16'h1234);
    check("pop_sp", sp, 8'h07);
    check("no_wrap_ovf", stack_ovf, 1'b0);

    for (int i = 0; i < 4; i++) run_op(4'd10, 1, lat, wes);
    check("pop_wrap_sp", sp, 8'hFF);
    check("pop_wrap_ovf", stack_ovf, OVF_EN);
    pc = 16'hBEEF;
    run_op(4'd11, 1, lat, wes);
    check("push_wrap_sp", sp, 8'h01);
    check("push_wrap_lo", mem[8'h00], 8'hEF);
    check("push_wrap_hi", mem[8'h01], 8'hBE);
    check("push_wrap_ovf", stack_ovf, OVF_EN);

    preload(8'h20, 8'h5C);
    opcode = 8'hD2; operand = 8'h01; access = 4'd9; start = 1'b1;
    @(posedge clock); #1 start = 1'b0;
    repeat (2) @(posedge clock);
    #1 check("bitwr_we_before", ram_we, 1'b1);
    reset = 1'b0;
    #1;
    check("abort_we", ram_we, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_sp", sp, 8'h07);
    check("abort_ovf", stack_ovf, 1'b0);
    @(posedge clock); #1;
    check("abort_mem", mem[8'h20], 8'h5C);
    @(negedge clock) reset = 1'b1;
    @(negedge clock);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
